mem_bus_fabric: RTL and testbench
=================================

MEM_BUS_FABRIC -- requirements
Module: mem_bus_fabric

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: master address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, range 1..16: slave region count.
REQ-004 SHALL have parameter REGION_SHIFT, default 16: low address bits passed to a slave; the upper bits select the region.
REQ-005 SHALL have parameter TIMEOUT, default 255: max ACCESS cycles; 0 disables the timeout.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port n_reset, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports m_req, m_we, m_addr, m_wdata; input; widths 1/1/ADDR_W/DATA_W: master request, write enable, address, write data.
REQ-009 SHALL have ports m_ready, m_err, m_rdata; output; widths 1/1/DATA_W: completion strobe, error flag, read data.
REQ-010 SHALL have ports s_sel, s_we, s_addr, s_wdata; output; widths NUM_SLAVES/1/REGION_SHIFT/DATA_W: one-hot slave select and forwarded access.
REQ-011 SHALL have ports s_rdata (NUM_SLAVES*DATA_W, slave i at bits [i*DATA_W +: DATA_W]) and s_ready (NUM_SLAVES); input: per-slave read data and completion.
REQ-012 SHALL have port err_count, output, 8: saturating count of error completions.

Function
REQ-013 SHALL implement the states IDLE, ACCESS and RESP.
REQ-014 IDLE: SHALL sample m_req each cycle; on m_req=1, SHALL latch m_we, m_addr and m_wdata and decode idx = m_addr[ADDR_W-1:REGION_SHIFT].
REQ-015 When idx < NUM_SLAVES, the transition IDLE->ACCESS SHALL occur with s_sel[idx]=1 from the next cycle and the timeout counter cleared.
REQ-016 When idx >= NUM_SLAVES (unmapped), the transition IDLE->RESP SHALL occur with m_err=1 and m_rdata=0, and no s_sel SHALL be asserted.
REQ-017 ACCESS: s_sel, s_we, s_addr (latched address low bits) and s_wdata SHALL be held stable; s_ready of non-selected slaves SHALL be ignored.
REQ-018 ACCESS with s_ready[idx]=1: SHALL capture the slave's s_rdata slice into m_rdata on reads (0 on writes), set m_err=0, move to RESP, and drop s_sel.
REQ-019 ACCESS without ready: the counter SHALL increment each cycle; when it equals TIMEOUT and TIMEOUT != 0, SHALL set m_err=1 and m_rdata=0 and move to RESP; a ready in that same cycle wins over the timeout.
REQ-020 RESP: m_ready=1 for exactly one cycle with m_rdata/m_err valid, then IDLE; m_ready=0 in all other states.
REQ-021 Latency: a zero-wait slave (ready in the first ACCESS cycle) SHALL complete with m_ready two cycles after m_req is sampled; an unmapped access SHALL complete one cycle after.
REQ-022 m_req SHALL be ignored outside IDLE; a master holding m_req after m_ready SHALL start a new access.
REQ-023 err_count SHALL increment on every RESP with m_err=1, saturating at 255.
REQ-024 The timeout counter width SHALL be clog2(TIMEOUT+1) with no wrap-around possible.

Reset
REQ-025 While n_reset=0, the fabric SHALL be in IDLE with m_ready, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata, err_count and the counter at 0, asynchronously.
REQ-026 Reset during ACCESS or RESP SHALL abort the access with no m_ready issued; the first request after release is accepted normally.

Structure
REQ-027 Package mem_bus_pkg SHALL hold the state enum, default parameter constants and the error-count width.
REQ-028 Combinational region decode (idx, mapped flag, one-hot) SHALL be sub-module mem_bus_decoder; the FSM and counters stay in mem_bus_fabric.

Verification
REQ-029 Read of 0x0001_0010 with slave 1 ready immediately and returning 0xDEADBEEF -> s_addr=0x0010, m_ready on cycle 2, m_rdata=0xDEADBEEF, m_err=0.
REQ-030 Write of 0x1234_5678 to 0x0000_0004 with slave 0 ready after 3 wait cycles -> s_we=1 and s_wdata held 4 cycles, m_ready on cycle 5, m_err=0.
REQ-031 Access to 0x0007_0000 (NUM_SLAVES=4) -> s_sel stays 0, m_ready cycle 1, m_err=1, err_count=1.
REQ-032 TIMEOUT=8, slave 2 never ready -> m_err=1, m_rdata=0 after 8 ACCESS cycles; ready arriving on cycle 8 -> m_err=0.
REQ-033 n_reset pulsed low mid-ACCESS -> all outputs 0 immediately, no m_ready, next read completes normally.
REQ-034 300 unmapped accesses -> err_count saturates at 255.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus fabric.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_NUM_SLAVES   = 4;
   localparam int DEF_REGION_SHIFT = 16;
   localparam int DEF_TIMEOUT      = 255;

   localparam int                    ERR_CNT_W   = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational region decode: region field -> one-hot select, index, mapped flag.
module mem_bus_decoder
   import mem_bus_pkg::*;
#(
   parameter int IDX_W      = DEF_ADDR_W - DEF_REGION_SHIFT,
   parameter int NUM_SLAVES = DEF_NUM_SLAVES,
   parameter int SEL_W      = min1_clog2(DEF_NUM_SLAVES)
) (
   input  logic [IDX_W-1:0]      region_i,
   output logic [NUM_SLAVES-1:0] onehot_o,
   output logic [SEL_W-1:0]      idx_o,
   output logic                  mapped_o
);

   // Compare the full region field against every slave number so that any
   // region >= NUM_SLAVES matches nothing and is reported as unmapped.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (region_i == IDX_W'(i)) begin
            onehot_o[i] = 1'b1;
            idx_o       = SEL_W'(i);
         end
      end
      mapped_o = |onehot_o;
   end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master to NUM_SLAVES memory bus fabric with region decode,
// per-access timeout and a saturating error counter.
module mem_bus_fabric
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int NUM_SLAVES   = DEF_NUM_SLAVES,
   parameter int REGION_SHIFT = DEF_REGION_SHIFT,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         n_reset,
   input  logic                         m_req,
   input  logic                         m_we,
   input  logic [ADDR_W-1:0]            m_addr,
   input  logic [DATA_W-1:0]            m_wdata,
   output logic                         m_ready,
   output logic                         m_err,
   output logic [DATA_W-1:0]            m_rdata,
   output logic [NUM_SLAVES-1:0]        s_sel,
   output logic                         s_we,
   output logic [REGION_SHIFT-1:0]      s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   output logic [ERR_CNT_W-1:0]         err_count
);

   localparam int IDX_W = ADDR_W - REGION_SHIFT;
   localparam int SEL_W = min1_clog2(NUM_SLAVES);
   // Counter only ever reaches TIMEOUT, so it never wraps.
   localparam int CNT_W = min1_clog2(TIMEOUT + 1);

   state_e                  state_q;
   logic                    m_ready_q, m_err_q, s_we_q;
   logic [DATA_W-1:0]       m_rdata_q, s_wdata_q;
   logic [NUM_SLAVES-1:0]   s_sel_q;
   logic [REGION_SHIFT-1:0] s_addr_q;
   logic [SEL_W-1:0]        idx_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ERR_CNT_W-1:0]    err_cnt_q;

   logic [NUM_SLAVES-1:0]   dec_onehot;
   logic [SEL_W-1:0]        dec_idx;
   logic                    dec_mapped;
   logic                    slv_ready;
   logic [DATA_W-1:0]       slv_rdata;

   mem_bus_decoder #(
      .IDX_W      (IDX_W),
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_W      (SEL_W)
   ) u_dec (
      .region_i (m_addr[ADDR_W-1:REGION_SHIFT]),
      .onehot_o (dec_onehot),
      .idx_o    (dec_idx),
      .mapped_o (dec_mapped)
   );

   // Pick ready and read data of the latched slave only; others are ignored.
   always_comb begin
      slv_ready = 1'b0;
      slv_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            slv_ready = s_ready[i];
            slv_rdata = s_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Access FSM with registered master/slave outputs, timeout and error count.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= ST_IDLE;
         m_ready_q <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
         s_sel_q   <= '0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (m_req) begin
                  s_we_q    <= m_we;
                  s_addr_q  <= m_addr[REGION_SHIFT-1:0];
                  s_wdata_q <= m_wdata;
                  cnt_q     <= '0;
                  if (dec_mapped) begin
                     s_sel_q <= dec_onehot;
                     idx_q   <= dec_idx;
                     state_q <= ST_ACCESS;
                  end else begin
                     m_err_q   <= 1'b1;
                     m_rdata_q <= '0;
                     m_ready_q <= 1'b1;
                     state_q   <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               if (slv_ready) begin
                  // A ready in the timeout cycle still completes cleanly.
                  m_rdata_q <= s_we_q ? '0 : slv_rdata;
                  m_err_q   <= 1'b0;
                  m_ready_q <= 1'b1;
                  s_sel_q   <= '0;
                  state_q   <= ST_RESP;
               end else if (TIMEOUT != 0) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                     m_rdata_q <= '0;
                     m_err_q   <= 1'b1;
                     m_ready_q <= 1'b1;
                     s_sel_q   <= '0;
                     state_q   <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (m_err_q && (err_cnt_q != ERR_CNT_MAX)) begin
                  err_cnt_q <= err_cnt_q + 1'b1;
               end
               m_ready_q <= 1'b0;
               m_err_q   <= 1'b0;
               m_rdata_q <= '0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_ready   = m_ready_q;
   assign m_err     = m_err_q;
   assign m_rdata   = m_rdata_q;
   assign s_sel     = s_sel_q;
   assign s_we      = s_we_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed table-driven bench for mem_bus_fabric (4 slaves, TIMEOUT=8).
module tb_mem_bus_fabric;

   localparam logic [127:0] RD_ALL = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

   logic         clk, n_reset;
   logic         m_req, m_we;
   logic [31:0]  m_addr, m_wdata;
   logic         m_ready, m_err;
   logic [31:0]  m_rdata;
   logic [3:0]   s_sel;
   logic         s_we;
   logic [15:0]  s_addr;
   logic [31:0]  s_wdata;
   logic [127:0] s_rdata;
   logic [3:0]   s_ready;
   logic [7:0]   err_count;

   int checks   = 0;
   int failures = 0;
   int exp_errs = 0;

   mem_bus_fabric #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .REGION_SHIFT(16), .TIMEOUT(8)
   ) dut (
      .clk(clk), .n_reset(n_reset),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
      .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          rdy_cyc;   // ACCESS cycle in which rdy_mask is driven (0 = never)
      logic [3:0]  rdy_mask;
      logic [3:0]  noise;     // s_ready driven on all other cycles
      logic [3:0]  exp_sel;
      int          exp_lat;   // cycle of m_ready, counted from the m_req sample edge
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [15:0] exp_saddr;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input int rdy_cyc, input logic [3:0] rdy_mask, input logic [3:0] noise,
                               input logic [3:0] exp_sel, input int exp_lat, input logic exp_err,
                               input logic [31:0] exp_rdata, input logic [15:0] exp_saddr);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.rdy_cyc = rdy_cyc; v.rdy_mask = rdy_mask;
      v.noise = noise; v.exp_sel = exp_sel; v.exp_lat = exp_lat; v.exp_err = exp_err;
      v.exp_rdata = exp_rdata; v.exp_saddr = exp_saddr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".m_ready"}, 64'(m_ready), 64'd0);
      chk({nm, ".m_err"}, 64'(m_err), 64'd0);
      chk({nm, ".m_rdata"}, 64'(m_rdata), 64'd0);
      chk({nm, ".s_sel"}, 64'(s_sel), 64'd0);
      chk({nm, ".s_we"}, 64'(s_we), 64'd0);
      chk({nm, ".s_addr"}, 64'(s_addr), 64'd0);
      chk({nm, ".s_wdata"}, 64'(s_wdata), 64'd0);
      chk({nm, ".err_count"}, 64'(err_count), 64'd0);
   endtask

   // Caller is #1 after a posedge with the fabric idle.
   task automatic run_vec(input int n, input vec_t v);
      int  cyc;
      bit  done;
      m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata;
      s_rdata = RD_ALL; s_ready = 4'b0;
      @(posedge clk); #1;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      cyc  = 1;
      done = 1'b0;
      while (!done && cyc <= 20) begin
         chk($sformatf("v%0d.s_sel", n), 64'(s_sel), m_ready ? 64'd0 : 64'(v.exp_sel));
         if (m_ready) begin
            chk($sformatf("v%0d.latency", n), 64'(cyc), 64'(v.exp_lat));
            chk($sformatf("v%0d.m_err", n), 64'(m_err), 64'(v.exp_err));
            chk($sformatf("v%0d.m_rdata", n), 64'(m_rdata), 64'(v.exp_rdata));
            done = 1'b1;
         end else begin
            if (v.exp_sel != 4'b0) begin
               chk($sformatf("v%0d.s_addr", n), 64'(s_addr), 64'(v.exp_saddr));
               chk($sformatf("v%0d.s_we", n), 64'(s_we), 64'(v.we));
               chk($sformatf("v%0d.s_wdata", n), 64'(s_wdata), 64'(v.wdata));
            end
            s_ready = (cyc == v.rdy_cyc) ? v.rdy_mask : v.noise;
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!done) chk($sformatf("v%0d.no_m_ready", n), 64'd0, 64'd1);
      s_ready = 4'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d.m_ready_pulse", n), 64'(m_ready), 64'd0);
      if (v.exp_err) exp_errs = (exp_errs >= 255) ? 255 : exp_errs + 1;
      chk($sformatf("v%0d.err_count", n), 64'(err_count), 64'(exp_errs));
   endtask

   initial begin
      int pulses;
      int budget;

      vecs[0] = mk(1'b0, 32'h0001_0010, 32'h0,         1, 4'b0010, 4'b0000, 4'b0010, 2, 1'b0, 32'hDEAD_BEEF, 16'h0010);
      vecs[1] = mk(1'b1, 32'h0000_0004, 32'h1234_5678, 4, 4'b0001, 4'b1110, 4'b0001, 5, 1'b0, 32'h0,         16'h0004);
      vecs[2] = mk(1'b0, 32'h0007_0000, 32'h0,         0, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1, 32'h0,         16'h0000);
      vecs[3] = mk(1'b0, 32'h0002_ABCD, 32'h0,         0, 4'b0000, 4'b1011, 4'b0100, 9, 1'b1, 32'h0,         16'hABCD);
      vecs[4] = mk(1'b0, 32'h0002_0100, 32'h0,         8, 4'b0100, 4'b0000, 4'b0100, 9, 1'b0, 32'h2222_2222, 16'h0100);
      vecs[5] = mk(1'b0, 32'h0003_FFFC, 32'h0,         1, 4'b1111, 4'b0000, 4'b1000, 2, 1'b0, 32'h3333_3333, 16'hFFFC);
      vecs[6] = mk(1'b1, 32'h0003_0008, 32'hCAFE_F00D, 1, 4'b1000, 4'b0000, 4'b1000, 2, 1'b0, 32'h0,         16'h0008);
      vecs[7] = mk(1'b0, 32'hFFFF_0000, 32'h0,         0, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1, 32'h0,         16'h0000);
      vecs[8] = mk(1'b0, 32'h0000_0040, 32'h0,         3, 4'b0001, 4'b0110, 4'b0001, 4, 1'b0, 32'h1111_1111, 16'h0040);

      n_reset = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      s_rdata = RD_ALL; s_ready = 4'b1111;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      s_ready = 4'b0;
      n_reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a write access: everything clears at once.
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0001_0020; m_wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      m_req = 1'b0;
      chk("midrst.s_we_before", 64'(s_we), 64'd1);
      @(posedge clk); #1;
      n_reset = 1'b0;
      #1;
      chk_all_zero("midrst");
      s_ready = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("midrst.no_m_ready", 64'(m_ready), 64'd0);
      end
      @(negedge clk);
      s_ready = 4'b0;
      n_reset = 1'b1;
      exp_errs = 0;
      @(posedge clk); #1;
      run_vec(100, vecs[0]);

      // Held m_req: ignored in RESP, re-accepted once back in IDLE.
      m_req = 1'b1; m_addr = 32'h0005_0000;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("hold.m_ready_c%0d", c), 64'(m_ready), 64'(c % 2));
      end
      m_req = 1'b0;
      exp_errs += 2;
      @(posedge clk); #1;
      chk("hold.err_count", 64'(err_count), 64'(exp_errs));

      // Back-to-back unmapped accesses drive err_count into saturation.
      m_req = 1'b1; m_addr = 32'h0004_0000;
      pulses = 0;
      budget = 0;
      while (pulses < 298 && budget < 1000) begin
         @(posedge clk); #1;
         budget++;
         if (m_ready) pulses++;
      end
      m_req = 1'b0;
      chk("sat.pulses", 64'(pulses), 64'd298);
      repeat (3) @(posedge clk);
      #1;
      chk("sat.err_count", 64'(err_count), 64'd255);
      exp_errs = 255;
      run_vec(200, vecs[2]);
      run_vec(201, vecs[5]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
